// File: rtl/seg7_scan_decoder.sv
// Loopback monitor: decodes the active-low 7-segment stream of a scanned display back into hex nibbles.
// Optional decimal-point capture is enabled with SEG7_DP_EN (8-bit seg_in plus dp_out port).
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SEG7_DP_EN
  input  logic [7:0]            seg_in,
`else
  input  logic [6:0]            seg_in,
`endif
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  upd,
  output logic                  err
`ifdef SEG7_DP_EN
  ,output logic [DIGITS-1:0]    dp_out
`endif
);

`ifdef SEG7_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam int WW = DIGITS + SEG_W;
  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] S_R = RW'(STABLE_CYCLES);
  localparam logic [6:0] BLANK = 7'b1111111;

  logic [WW-1:0] w, last;
  logic [RW-1:0] r, r_next;
  logic          same, accept;
  logic          sel_zero, sel_multi;
  logic          dec_hit;
  logic [3:0]    dec_nib;
  logic          is_blank;

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] d;
    case (s)
      7'b1000000: d = {1'b1, 4'h0};
      7'b1111001: d = {1'b1, 4'h1};
      7'b0100100: d = {1'b1, 4'h2};
      7'b0110000: d = {1'b1, 4'h3};
      7'b0011001: d = {1'b1, 4'h4};
      7'b0010010: d = {1'b1, 4'h5};
      7'b0000010: d = {1'b1, 4'h6};
      7'b1111000: d = {1'b1, 4'h7};
      7'b0000000: d = {1'b1, 4'h8};
      7'b0010000: d = {1'b1, 4'h9};
      7'b0001000: d = {1'b1, 4'hA};
      7'b0000011: d = {1'b1, 4'hB};
      7'b1000110: d = {1'b1, 4'hC};
      7'b0100001: d = {1'b1, 4'hD};
      7'b0000110: d = {1'b1, 4'hE};
      7'b0001110: d = {1'b1, 4'hF};
      default:    d = 5'b0;
    endcase
    return d;
  endfunction

  assign w = {dig_sel, seg_in};

  // A run continues only while W repeats and a run is in progress (r==0 after reset/clr).
  always_comb begin
    same   = (w == last) && (r != '0);
    r_next = RW'(1);
    if (same) r_next = (r == S_R) ? S_R : r + RW'(1);
    // Fires only on the edge the count first lands on STABLE_CYCLES; saturated holds stay quiet.
    accept = (r_next == S_R) && !(same && (r == S_R));
  end

  assign sel_zero  = (dig_sel == '0);
  assign sel_multi = |(dig_sel & (dig_sel - DIGITS'(1)));
  assign {dec_hit, dec_nib} = decode(seg_in[6:0]);
  assign is_blank  = (seg_in[6:0] == BLANK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last        <= '0;
      r           <= '0;
      value       <= '0;
      digit_valid <= '0;
      upd         <= 1'b0;
      err         <= 1'b0;
`ifdef SEG7_DP_EN
      dp_out      <= '0;
`endif
    end else begin
      last <= w;
      upd  <= 1'b0;
      if (clr) begin
        r           <= '0;
        value       <= '0;
        digit_valid <= '0;
        err         <= 1'b0;
`ifdef SEG7_DP_EN
        dp_out      <= '0;
`endif
      end else begin
        r <= r_next;
        if (accept && !sel_zero) begin
          if (sel_multi) begin
            err <= 1'b1;
          end else if (dec_hit) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (dig_sel[i]) begin
                value[4*i +: 4] <= dec_nib;
                digit_valid[i]  <= 1'b1;
`ifdef SEG7_DP_EN
                dp_out[i]       <= ~seg_in[7];
`endif
              end
            end
            upd <= 1'b1;
          end else if (is_blank) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (dig_sel[i]) begin
                digit_valid[i] <= 1'b0;
`ifdef SEG7_DP_EN
                dp_out[i]      <= ~seg_in[7];
`endif
              end
            end
          end else begin
            err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus random scan traffic against a run-length model.
module tb_seg7_scan_decoder;
  localparam int DIGITS = 4;
  localparam int STABLE = 3;
`ifdef SEG7_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif

  logic                 clk, rst_n, clr;
  logic [SW-1:0]        seg_in;
  logic [DIGITS-1:0]    dig_sel;
  logic [4*DIGITS-1:0]  value;
  logic [DIGITS-1:0]    digit_valid;
  logic                 upd, err;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]    dp_out;
`endif

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel), .clr(clr),
    .value(value), .digit_valid(digit_valid), .upd(upd), .err(err)
`ifdef SEG7_DP_EN
    , .dp_out(dp_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Segment patterns for hex digits 0..F, indexed by digit value.
  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: counts how many consecutive edges the same word has been seen.
  logic [4*DIGITS-1:0]   m_value;
  logic [DIGITS-1:0]     m_valid, m_dp;
  logic                  m_upd, m_err;
  logic [SW+DIGITS-1:0]  prev_w;
  int                    run;
  int                    upd_seen;

  task automatic model_reset();
    m_value = '0; m_valid = '0; m_dp = '0; m_upd = 0; m_err = 0;
    prev_w = '0; run = 0;
  endtask

  task automatic model_apply();
    int n, idx, hit;
    n = $countones(dig_sel);
    if (n > 1) m_err = 1;
    else if (n == 1) begin
      idx = 0;
      for (int k = 0; k < DIGITS; k++) if (dig_sel[k]) idx = k;
      hit = -1;
      for (int k = 0; k < 16; k++) if (tbl[k] == seg_in[6:0]) hit = k;
      if (hit >= 0) begin
        m_value[4*idx +: 4] = 4'(hit);
        m_valid[idx] = 1;
        m_upd = 1;
`ifdef SEG7_DP_EN
        m_dp[idx] = ~seg_in[7];
`endif
      end else if (seg_in[6:0] == 7'h7F) begin
        m_valid[idx] = 0;
`ifdef SEG7_DP_EN
        m_dp[idx] = ~seg_in[7];
`endif
      end else m_err = 1;
    end
  endtask

  task automatic model_edge();
    logic [SW+DIGITS-1:0] w;
    w = {dig_sel, seg_in};
    m_upd = 0;
    if (clr) begin
      m_value = '0; m_valid = '0; m_dp = '0; m_err = 0; run = 0;
    end else begin
      if (run > 0 && w == prev_w) run++;
      else run = 1;
      if (run == STABLE) model_apply();
    end
    prev_w = w;
  endtask

  // Drives one cycle of inputs; returns at the following falling edge.
  task automatic step(input logic [DIGITS-1:0] sel, input logic [6:0] seg, input logic dp_on, input logic c);
    dig_sel = sel;
`ifdef SEG7_DP_EN
    seg_in = {~dp_on, seg};
`else
    seg_in = seg;
    if (dp_on) seg_in = seg;
`endif
    clr = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (upd === 1'b1) upd_seen++;
  endtask

  task automatic apply_reset();
    rst_n = 0; clr = 0; dig_sel = '0; seg_in = '1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (value !== '0)       begin bad++; $display("FAIL reset_value got=%h exp=0", value); end
    total++; if (digit_valid !== '0) begin bad++; $display("FAIL reset_valid got=%b exp=0", digit_valid); end
    total++; if (upd !== 1'b0)       begin bad++; $display("FAIL reset_upd got=%b exp=0", upd); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_basic_accept();
    apply_reset();
    upd_seen = 0;
    for (int c = 1; c <= 13; c++) begin
      step(4'b0001, 7'b0100100, 0, 0);
      total++;
      if (upd !== (c == STABLE)) begin bad++; $display("FAIL basic_upd_cycle%0d got=%b exp=%b", c, upd, c == STABLE); end
      if (c == STABLE - 1) begin
        total++; if (digit_valid !== '0) begin bad++; $display("FAIL basic_early got=%b exp=0", digit_valid); end
      end
    end
    total++; if (value[3:0] !== 4'h2)      begin bad++; $display("FAIL basic_value got=%h exp=2", value[3:0]); end
    total++; if (digit_valid !== 4'b0001)  begin bad++; $display("FAIL basic_valid got=%b exp=0001", digit_valid); end
    total++; if (upd_seen != 1)            begin bad++; $display("FAIL basic_upd_count got=%0d exp=1", upd_seen); end
  endtask

  task automatic test_short_runs();
    apply_reset();
    upd_seen = 0;
    repeat (2) step(4'b0010, 7'b0110000, 0, 0);
    repeat (2) step(4'b0010, 7'b0011001, 0, 0);
    total++; if (upd_seen != 0)        begin bad++; $display("FAIL short_upd got=%0d exp=0", upd_seen); end
    total++; if (value !== '0)         begin bad++; $display("FAIL short_value got=%h exp=0", value); end
    total++; if (digit_valid !== '0)   begin bad++; $display("FAIL short_valid got=%b exp=0", digit_valid); end
  endtask

  task automatic test_scan();
    logic [3:0] nib [4] = '{4'h1, 4'h2, 4'h3, 4'hF};
    apply_reset();
    upd_seen = 0;
    for (int d = 0; d < DIGITS; d++) begin
      repeat (5) step(4'(1 << d), tbl[nib[d]], 0, 0);
      step('0, 7'h7F, 0, 0);
    end
    total++; if (value !== 16'hF321)      begin bad++; $display("FAIL scan_value got=%h exp=F321", value); end
    total++; if (digit_valid !== 4'b1111) begin bad++; $display("FAIL scan_valid got=%b exp=1111", digit_valid); end
    total++; if (upd_seen != 4)           begin bad++; $display("FAIL scan_upd_count got=%0d exp=4", upd_seen); end
  endtask

  task automatic test_err_blank();
    upd_seen = 0;
    repeat (3) step(4'b0010, 7'b1010101, 0, 0);
    total++; if (err !== 1'b1)        begin bad++; $display("FAIL badpat_err got=%b exp=1", err); end
    total++; if (value !== 16'hF321)  begin bad++; $display("FAIL badpat_value got=%h exp=F321", value); end
    repeat (3) step(4'b0001, 7'b1111111, 0, 0);
    total++; if (digit_valid !== 4'b1110) begin bad++; $display("FAIL blank_valid got=%b exp=1110", digit_valid); end
    total++; if (err !== 1'b1)            begin bad++; $display("FAIL blank_err got=%b exp=1", err); end
    total++; if (value !== 16'hF321)      begin bad++; $display("FAIL blank_value got=%h exp=F321", value); end
    total++; if (upd_seen != 0)           begin bad++; $display("FAIL errblank_upd got=%0d exp=0", upd_seen); end
  endtask

  task automatic test_multihot_clr();
    apply_reset();
    upd_seen = 0;
    repeat (3) step(4'b0011, tbl[5], 0, 0);
    total++; if (err !== 1'b1)       begin bad++; $display("FAIL multihot_err got=%b exp=1", err); end
    total++; if (digit_valid !== '0) begin bad++; $display("FAIL multihot_valid got=%b exp=0", digit_valid); end
    total++; if (upd_seen != 0)      begin bad++; $display("FAIL multihot_upd got=%0d exp=0", upd_seen); end
    repeat (2) step(4'b0100, tbl[8], 0, 0);
    step(4'b0100, tbl[8], 0, 1);
    total++; if ({value, digit_valid, upd, err} !== '0) begin bad++;
      $display("FAIL clr_priority got=%h/%b/%b/%b exp=all zero", value, digit_valid, upd, err); end
    step(4'b0100, tbl[8], 0, 0);
    step(4'b0100, tbl[8], 0, 0);
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL clr_restart_early got=%b exp=0", upd); end
    step(4'b0100, tbl[8], 0, 0);
    total++; if (value[11:8] !== 4'h8 || upd !== 1'b1) begin bad++;
      $display("FAIL clr_restart got=%h/%b exp=8/1", value[11:8], upd); end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    repeat (3) step(4'b1000, tbl[9], 0, 0);
    repeat (2) step(4'b0001, tbl[4], 0, 0);
    #2 rst_n = 0;
    #1;
    total++; if (value !== '0 || digit_valid !== '0) begin bad++;
      $display("FAIL async_reset got=%h/%b exp=0/0", value, digit_valid); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    upd_seen = 0;
    repeat (2) step(4'b0001, tbl[4], 0, 0);
    total++; if (upd_seen != 0 || digit_valid !== '0) begin bad++;
      $display("FAIL post_reset_early got=%0d/%b exp=0/0", upd_seen, digit_valid); end
    step(4'b0001, tbl[4], 0, 0);
    total++; if (upd !== 1'b1 || value[3:0] !== 4'h4) begin bad++;
      $display("FAIL post_reset_accept got=%b/%h exp=1/4", upd, value[3:0]); end
  endtask

`ifdef SEG7_DP_EN
  task automatic test_dp();
    apply_reset();
    repeat (3) step(4'b0100, 7'b0000010, 1, 0);
    total++; if (value[11:8] !== 4'h6) begin bad++; $display("FAIL dp_value got=%h exp=6", value[11:8]); end
    total++; if (dp_out !== 4'b0100)   begin bad++; $display("FAIL dp_out got=%b exp=0100", dp_out); end
  endtask
`endif

  task automatic test_random();
    logic [DIGITS-1:0] sel;
    logic [6:0]        seg;
    logic              dp_on;
    int                len, kind;
    apply_reset();
    for (int n = 0; n < 160; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7) sel = 4'(1 << $urandom_range(0, DIGITS - 1));
      else if (kind == 7) sel = '0;
      else begin
        sel = 4'($urandom_range(0, 15));
        while ($countones(sel) < 2) sel = 4'($urandom_range(0, 15));
      end
      kind = $urandom_range(0, 9);
      if (kind < 7) seg = tbl[$urandom_range(0, 15)];
      else if (kind < 9) seg = 7'h7F;
      else seg = 7'($urandom_range(0, 127));
      dp_on = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 5);
      for (int c = 0; c < len; c++) begin
        step(sel, seg, dp_on, ($urandom_range(0, 39) == 0));
        total++; if (value !== m_value)       begin bad++; $display("FAIL rand_value n=%0d got=%h exp=%h", n, value, m_value); end
        total++; if (digit_valid !== m_valid) begin bad++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, digit_valid, m_valid); end
        total++; if (upd !== m_upd)           begin bad++; $display("FAIL rand_upd n=%0d got=%b exp=%b", n, upd, m_upd); end
        total++; if (err !== m_err)           begin bad++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, err, m_err); end
`ifdef SEG7_DP_EN
        total++; if (dp_out !== m_dp)         begin bad++; $display("FAIL rand_dp n=%0d got=%b exp=%b", n, dp_out, m_dp); end
`endif
      end
    end
  endtask

  initial begin
    rst_n = 0; clr = 0; dig_sel = '0; seg_in = '1;
    upd_seen = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_accept();
    test_short_runs();
    test_scan();
    test_err_blank();
    test_multihot_clr();
    test_reset_midrun();
`ifdef SEG7_DP_EN
    test_dp();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
